// File: rtl/bcd_counter_n_pkg.sv
// Shared constants, digit type and terminal-value helper for the bcd_counter_n family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_counter_n_pkg;

  localparam int unsigned DIGIT_W_DEFAULT = 4;
  localparam int unsigned MOD_DEC         = 10;

  typedef logic [DIGIT_W_DEFAULT-1:0] digit_t;

  // Value a digit sits at when it is about to wrap: MOD-1 counting up, 0 counting down.
  function automatic int unsigned terminal_value(input logic up, input int unsigned modulus);
    return up ? (modulus - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One modulo-MOD digit: parallel load with out-of-range clamp to 0, step up/down with wrap.
// Latency: 1 clock from load/step to q; at_max/at_min are combinational from q.
// Backpressure: none; step is a plain per-cycle enable from the carry chain.
module bcd_digit_cell
  import bcd_counter_n_pkg::*;
#(
  parameter int unsigned DIGIT_W = DIGIT_W_DEFAULT,
  parameter int unsigned MOD     = MOD_DEC
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] d,
  input  logic               step,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max,
  output logic               at_min
);

  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(terminal_value(1'b1, MOD));
  localparam logic [DIGIT_W-1:0] MIN_V = DIGIT_W'(terminal_value(1'b0, MOD));
  localparam logic [DIGIT_W-1:0] ONE_V = DIGIT_W'(1);

  logic d_ok;

  assign d_ok   = (32'(d) < MOD);
  assign at_max = (q == MAX_V);
  assign at_min = (q == MIN_V);

  // Digit register: reset > load (clamped) > step; a loaded digit can never leave the 0..MOD-1 range.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      q <= '0;
    end else if (load) begin
      q <= d_ok ? d : '0;
    end else if (step) begin
      if (up) begin
        q <= at_max ? MIN_V : (q + ONE_V);
      end else begin
        q <= at_min ? MAX_V : (q - ONE_V);
      end
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// DIGITS-digit cascaded modulo-MOD up/down counter with load range check; CNT_SATURATE_EN holds at the limits instead of wrapping.
// Latency: 1 clock from load/en/up to Q and load_err; Co is combinational from Q, en and up.
// Backpressure: none; en is a plain count enable and Co feeds the next instance's en.
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned DIGIT_W = DIGIT_W_DEFAULT,
  parameter int unsigned MOD     = MOD_DEC
) (
  input  logic                      clk,
  input  logic                      clrn,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] D,
  input  logic                      en,
  input  logic                      up,
  output logic [DIGITS*DIGIT_W-1:0] Q,
  output logic                      Co,
  output logic                      load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] d_bad;
  logic              at_limit;
  logic              cnt;

  // Whole counter sits at the terminal value for the current direction.
  assign at_limit = up ? (&at_max) : (&at_min);
  assign Co       = en & at_limit;

`ifdef CNT_SATURATE_EN
  // Freeze at the limit rather than rolling over.
  assign cnt = en & ~at_limit;
`else
  assign cnt = en;
`endif

  // Step chain: digit i moves when counting and every lower digit is at its terminal value.
  always_comb begin
    logic acc;
    step = '0;
    acc  = cnt;
    for (int i = 0; i < int'(DIGITS); i++) begin
      step[i] = acc;
      acc     = acc & (up ? at_max[i] : at_min[i]);
    end
  end

  // Flag each load digit that falls outside 0..MOD-1.
  always_comb begin
    d_bad = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d_bad[i] = (32'(D[i*DIGIT_W +: DIGIT_W]) >= MOD);
    end
  end

  // load_err reflects only the most recent load and is otherwise sticky.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      load_err <= 1'b0;
    end else if (load) begin
      load_err <= |d_bad;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell #(
      .DIGIT_W (DIGIT_W),
      .MOD     (MOD)
    ) u_cell (
      .clk    (clk),
      .clrn   (clrn),
      .load   (load),
      .d      (D[g*DIGIT_W +: DIGIT_W]),
      .step   (step[g]),
      .up     (up),
      .q      (Q[g*DIGIT_W +: DIGIT_W]),
      .at_max (at_max[g]),
      .at_min (at_min[g])
    );
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n: vector table, corner sequences, random run against a value-level model.
// Latency: expects Q one clock after the driving edge, Co combinational.
// Backpressure: none.
module tb_bcd_counter_n;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned DW     = 4;
  localparam int unsigned MOD    = 10;
  localparam int unsigned W      = DIGITS * DW;
  localparam int unsigned NMAX   = MOD ** DIGITS;

  logic         clk = 1'b0;
  logic         clrn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] D = '0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic [W-1:0] Q;
  logic         Co;
  logic         load_err;

  // second instance: 3 digits, modulus 6
  logic         load2 = 1'b0;
  logic [11:0]  d2 = '0;
  logic         en2 = 1'b0;
  logic         up2 = 1'b1;
  logic [11:0]  q2;
  logic         co2;
  logic         err2;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: counter as a plain integer 0..NMAX-1
  int unsigned mv   = 0;
  bit          merr = 1'b0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(DIGITS), .DIGIT_W(DW), .MOD(MOD)) dut (
    .clk(clk), .clrn(clrn), .load(load), .D(D), .en(en), .up(up),
    .Q(Q), .Co(Co), .load_err(load_err)
  );

  bcd_counter_n #(.DIGITS(3), .DIGIT_W(4), .MOD(6)) dut6 (
    .clk(clk), .clrn(clrn), .load(load2), .D(d2), .en(en2), .up(up2),
    .Q(q2), .Co(co2), .load_err(err2)
  );

  typedef struct {
    logic         load;
    logic [W-1:0] d;
    logic         en;
    logic         up;
    logic [W-1:0] q;
    logic         err;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] q_of(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[i*DW +: DW] = DW'(t % MOD);
      t = t / MOD;
    end
    return r;
  endfunction

  function automatic bit model_co(input logic e, input logic u);
    return e && (u ? (mv == NMAX - 1) : (mv == 0));
  endfunction

  task automatic model_edge(input logic l, input logic [W-1:0] d, input logic e, input logic u);
    int unsigned v, mult, dig;
    bit bad;
    if (l) begin
      v = 0; mult = 1; bad = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig = 32'(d[i*DW +: DW]);
        if (dig >= MOD) begin
          bad = 1'b1;
          dig = 0;
        end
        v += dig * mult;
        mult *= MOD;
      end
      mv = v;
      merr = bad;
    end else if (e) begin
      if (u) begin
`ifdef CNT_SATURATE_EN
        if (mv != NMAX - 1) mv = mv + 1;
`else
        mv = (mv + 1) % NMAX;
`endif
      end else begin
`ifdef CNT_SATURATE_EN
        if (mv != 0) mv = mv - 1;
`else
        mv = (mv + NMAX - 1) % NMAX;
`endif
      end
    end
  endtask

  // one clock: drive, check Co before the edge, advance, check Q/load_err after
  task automatic cycle(input string tag, input logic l, input logic [W-1:0] d, input logic e, input logic u);
    load = l; D = d; en = e; up = u;
    #1;
    chk({tag, "_co"}, 32'(Co), 32'(model_co(e, u)));
    @(posedge clk);
    #1;
    model_edge(l, d, e, u);
    chk({tag, "_q"}, 32'(Q), 32'(q_of(mv)));
    chk({tag, "_err"}, 32'(load_err), 32'(merr));
  endtask

  // asynchronous reset pulse asserted between edges
  task automatic async_reset();
    @(negedge clk);
    clrn = 1'b1;
    #1;
    mv = 0; merr = 1'b0;
    chk("arst_q", 32'(Q), 32'h0);
    chk("arst_err", 32'(load_err), 32'h0);
    @(negedge clk);
    clrn = 1'b0;
    #1;
  endtask

  initial begin
    vt[0]  = '{1'b1, 8'h47, 1'b0, 1'b1, 8'h47, 1'b0};
    vt[1]  = '{1'b1, 8'h4C, 1'b0, 1'b1, 8'h40, 1'b1};
    vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b1};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 1'b1};
    vt[4]  = '{1'b1, 8'h12, 1'b0, 1'b1, 8'h12, 1'b0};
    vt[5]  = '{1'b1, 8'h38, 1'b0, 1'b1, 8'h38, 1'b0};
    vt[6]  = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h05, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 1'b0};
    vt[9]  = '{1'b1, 8'hF9, 1'b0, 1'b0, 8'h09, 1'b1};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h08, 1'b1};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h09, 1'b1};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b1};
    vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b1};

    // reset state
    clrn = 1'b1;
    #2;
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_err", 32'(load_err), 32'h0);
    chk("rst_co_idle", 32'(Co), 32'h0);
    @(negedge clk);
    clrn = 1'b0;
    #1;

    // vector table (also kept in step with the model)
    foreach (vt[k]) begin
      load = vt[k].load; D = vt[k].d; en = vt[k].en; up = vt[k].up;
      @(posedge clk);
      #1;
      model_edge(vt[k].load, vt[k].d, vt[k].en, vt[k].up);
      chk($sformatf("vec%0d_q", k), 32'(Q), 32'(vt[k].q));
      chk($sformatf("vec%0d_err", k), 32'(load_err), 32'(vt[k].err));
    end

    // full up run from reset: 100 clocks, Co only at 99, wraps to 00
    async_reset();
    for (int i = 0; i < 100; i++) begin
      cycle("uprun", 1'b0, '0, 1'b1, 1'b1);
    end
`ifndef CNT_SATURATE_EN
    chk("uprun_wrap", 32'(Q), 32'h00);
`endif

    // down from reset: Co during 00, then 99, then 99 more clocks back to 00
    async_reset();
    load = 1'b0; en = 1'b1; up = 1'b0;
    #1;
    chk("down_co_at00", 32'(Co), 32'h1);
    cycle("dn1", 1'b0, '0, 1'b1, 1'b0);
`ifndef CNT_SATURATE_EN
    chk("dn1_q99", 32'(Q), 32'h99);
`endif
    for (int i = 0; i < 99; i++) begin
      cycle("dnrun", 1'b0, '0, 1'b1, 1'b0);
    end
`ifndef CNT_SATURATE_EN
    chk("dnrun_q00", 32'(Q), 32'h00);
`endif

    // reset mid-count from 57, then first count after release gives 01
    cycle("ld57", 1'b1, 8'h57, 1'b0, 1'b1);
    chk("ld57_q", 32'(Q), 32'h57);
    async_reset();
    cycle("post_rst", 1'b0, '0, 1'b1, 1'b1);
    chk("post_rst_q01", 32'(Q), 32'h01);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
      end
      cycle("rnd", ($urandom_range(0, 9) == 0), W'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    load = 1'b0; en = 1'b0;

    // 3-digit modulus-6 instance at the top limit
    load2 = 1'b1; d2 = 12'h555; en2 = 1'b0; up2 = 1'b1;
    @(posedge clk);
    #1;
    chk("m6_load", 32'(q2), 32'h555);
    chk("m6_err", 32'(err2), 32'h0);
    load2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [11:0] exp_q;
      logic        exp_co;
`ifdef CNT_SATURATE_EN
      exp_co = 1'b1;
      exp_q  = 12'h555;
`else
      exp_co = (k == 0);
      exp_q  = 12'(k);
`endif
      #1;
      chk($sformatf("m6_co%0d", k), 32'(co2), 32'(exp_co));
      @(posedge clk);
      #1;
      chk($sformatf("m6_q%0d", k), 32'(q2), 32'(exp_q));
    end
    up2 = 1'b0;
    @(posedge clk);
    #1;
`ifdef CNT_SATURATE_EN
    chk("m6_down", 32'(q2), 32'h554);
`else
    chk("m6_down", 32'(q2), 32'h001);
`endif
    en2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
Name: bcd_counter_n

Overview:
Parametrised multi-digit synchronous modulo counter. Generalises the single-digit decade counter to DIGITS cascaded digits of arbitrary modulus, adds up/down counting and load-value checking. Used for display timers, event tallies and time-of-day chains; Co cascades into further instances.

Parameters:
DIGITS, 2, number of cascaded digits (1..8)
DIGIT_W, 4, bits per digit
MOD, 10, modulus of every digit (2 <= MOD <= 2**DIGIT_W)

Ports:
clk  in  1  single clock, rising edge
clrn  in  1  reset, asynchronous, active-high; clears all state
load  in  1  synchronous parallel load of D
D  in  DIGITS*DIGIT_W  load value, digit 0 in bits [DIGIT_W-1:0]
en  in  1  count enable
up  in  1  direction: 1 = increment, 0 = decrement
Q  out  DIGITS*DIGIT_W  registered count, same packing as D
Co  out  1  combinational carry/borrow-out for cascading
load_err  out  1  registered; a digit of the last load was out of range

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. clrn=1 forces Q=0 and load_err=0 immediately, independent of clk. Reset mid-count discards the count. First count edge after release uses Q=0.
- Priority at each rising clk: clrn > load > en > hold.
- load=1: each digit i takes D[i]. If D[i] >= MOD, digit i takes 0 instead. load_err is set to 1 if any digit was out of range, else 0. en and up are ignored on a load cycle.
- load_err holds its value until the next load or reset.
- en=0, load=0: Q holds.
- en=1, up=1: digit 0 increments. Digit i steps only when en=1 and all lower digits equal MOD-1. A stepping digit at MOD-1 wraps to 0, otherwise adds 1.
- en=1, up=0: digit 0 decrements. Digit i steps only when all lower digits equal 0. A stepping digit at 0 wraps to MOD-1, otherwise subtracts 1.
- Full wrap: up from all MOD-1 gives all 0; down from all 0 gives all MOD-1.
- Co = en & (up ? all digits == MOD-1 : all digits == 0). Co is combinational from registered Q, en and up, and is not gated by load.
- A direction change takes effect on the same edge. There is no pipeline; latency from en to Q is 1 cycle.
- Q never holds a digit >= MOD.
- All arithmetic is per-digit, DIGIT_W bits wide, with no binary carry between digits.

Optional Feature:
Macro CNT_SATURATE_EN.
- Defined: the counter saturates instead of wrapping. With en=1, up=1 and all digits at MOD-1, Q holds. With en=1, up=0 and all digits at 0, Q holds. Co still asserts under the same equation and means "at limit".
- Undefined: wrap-around as described above.
- Load and reset behaviour are identical in both builds.

Decomposition:
- Shared package holds:
  - constant DIGIT_W_DEFAULT=4;
  - constant MOD_DEC=10;
  - typedef of the digit vector;
  - a function returning the terminal value for a direction (MOD-1 or 0).
- One sub-module: bcd_digit_cell, a single digit. Inputs: clk, clrn, load, d, step, up. Outputs: q, at_max, at_min. The top instantiates DIGITS cells and builds the step chain as a prefix AND of the at_max / at_min outputs.

Test Plan (DIGITS=2, MOD=10 unless noted):
- Reset, then en=1, up=1 for 100 clocks -> Q steps 00..99 then wraps to 00. Co=1 only while Q=99.
- Reset, then en=1, up=0 for 1 clock -> Q=99 and Co was 1 during the Q=00 cycle. Run 99 more clocks -> Q back to 00.
- load=1, D=0x47 -> Q=0x47, load_err=0. Then load=1, D=0x4C -> Q=0x40, load_err=1. Next load 0x12 -> load_err=0.
- Q=0x38, load=1 and en=1 together with D=0x05 -> Q=0x05 (load wins). Next en=1, up=1 -> Q=0x06.
- Count to Q=0x57, assert clrn between edges -> Q=00 before the next edge. Release clrn, en=1 -> Q=01 after 1 clock.
- CNT_SATURATE_EN defined, DIGITS=3, MOD=6: load 0x555, en=1, up=1 for 3 clocks -> Q stays 0x555 with Co=1. up=0 -> Q=0x554 after 1 clock.
